serializer: RTL and testbench
=============================

// Module: serializer
// PURPOSE
//   Parallel-to-serial converter on the sample path of the FIR filter. It takes
//   LENGTH-bit words over a valid/ready handshake and shifts them out one bit
//   per enabled cycle, LSB first, to feed the deserializer.
//   A frame marker on the last bit of each word lets the deserializer latch
//   whole words. A one-word holding register allows back-to-back words with no
//   idle bits between them.
// PARAMETERS
//   LENGTH  24  word width in bits; legal range is LENGTH >= 2
// PORTS
//   i_clk         in   1       clock; all logic on the rising edge
//   i_rst_n       in   1       asynchronous reset, active-low
//   i_en          in   1       bit-rate strobe; one serial bit per cycle with i_en=1
//   iv_din        in   LENGTH  parallel input word
//   i_din_valid   in   1       iv_din valid
//   o_din_ready   out  1       holding register empty; can accept a word
//   o_dout        out  1       serial data bit, LSB first
//   o_dout_valid  out  1       frame marker; high while o_dout carries bit LENGTH-1
//   o_busy        out  1       a word is in the shifter or the holding register
// BEHAVIOUR
//   Reset (i_rst_n=0, takes effect immediately):
//   - hold, shifter and bit counter are cleared; hold_full=0; state=IDLE.
//   - o_dout=0, o_dout_valid=0, o_busy=0, o_din_ready=1.
//   - A word that is partly shifted out is dropped, with no marker.
//   Input side (independent of i_en):
//   - o_din_ready = ~hold_full, driven from a register only; no combinational
//     path from i_en or the shifter.
//   - A word is accepted when i_din_valid & o_din_ready: hold <= iv_din and
//     hold_full <= 1 on that edge.
//   - If i_din_valid=1 while o_din_ready=0, the input is ignored and hold is
//     unchanged.
//   - If hold is drained and a new word arrives on the same edge, the new word
//     is not accepted, because ready was low.
//   FSM states: IDLE, SHIFT. cnt has width $clog2(LENGTH+1) and holds the
//   number of bits of the current word already emitted.
//   - Cycles with i_en=0: no change to the shifter, cnt, state, o_dout or
//     o_dout_valid. The outputs hold their values between strobes.
//   - Cycles with i_en=1 and (state=IDLE or cnt=LENGTH), i.e. a load point:
//     - if hold_full: o_dout<=hold[0]; shreg<=hold>>1; cnt<=1; hold_full<=0;
//       state<=SHIFT; o_dout_valid<=0.
//     - else: o_dout<=0; o_dout_valid<=0; state<=IDLE; cnt<=0.
//   - Cycles with i_en=1 in SHIFT and cnt<LENGTH:
//     o_dout<=shreg[0]; shreg>>=1; cnt<=cnt+1; o_dout_valid<=(cnt==LENGTH-1).
//   - Latency: a word accepted on edge t is loaded at the first i_en=1 edge
//     after t, and its first bit appears on that edge.
//   - Back-to-back: if hold is full at the load point that follows the last
//     bit, bit 0 of the next word follows immediately, with no gap.
//   - o_busy = hold_full | (state==SHIFT & cnt<LENGTH).
//   Interface contract: a deserializer on the same i_en strobe samples each bit
//   one strobe later. When it sees the marker, its captured word equals the
//   transmitted word.
// TESTING
//   T1 reset: drive i_rst_n low mid-clock -> all outputs 0 and o_din_ready=1
//      before the next edge.
//   T2 single word, LENGTH=24, i_en=1 every cycle, iv_din=24'hA5C3F1 ->
//      o_dout = 1,0,0,0,1,1,1,1,... (LSB first); o_dout_valid high only with
//      the 24th bit; a looped-back deserializer outputs 24'hA5C3F1.
//   T3 back-to-back: present 24'h123456, 24'hABCDEF and 24'h000001 on
//      consecutive cycles ->
//      - word 2 is accepted while word 1 is shifting;
//      - word 3 stalls (ready=0) until word 2 loads;
//      - 72 contiguous bits with markers at bits 24, 48 and 72.
//   T4 i_en asserted every 4th cycle, word 24'hFFFFFE ->
//      - each bit is held for 4 clocks;
//      - the marker is held for 4 clocks;
//      - the word is received intact.
//   T5 reset after 10 bits of 24'h0F0F0F, then send 24'h800000 ->
//      - no marker for the aborted word;
//      - the next word is sent complete, with a 1 on the 24th bit together
//        with the marker.
//   T6 hold i_din_valid=1 with 24'hDEAD00 while ready=0 ->
//      - hold keeps its earlier word;
//      - the new word is accepted exactly once, when ready rises.

Source files
------------

// File: rtl/serializer.sv
// Parallel-to-serial converter, LSB first, with a one-word holding register.
// A frame marker accompanies the last bit of every word.
module serializer #(
   parameter int LENGTH = 24
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_en,
   input  logic [LENGTH-1:0] iv_din,
   input  logic              i_din_valid,
   output logic              o_din_ready,
   output logic              o_dout,
   output logic              o_dout_valid,
   output logic              o_busy
);

   localparam int CW = $clog2(LENGTH + 1);
   localparam logic [CW-1:0] LEN_C  = CW'(LENGTH);
   localparam logic [CW-1:0] LAST_C = CW'(LENGTH - 1);
   localparam logic [CW-1:0] ONE_C  = CW'(1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [LENGTH-1:0] hold;
   logic [LENGTH-1:0] shreg;
   logic              hold_full;
   logic              accept;
   logic              load_pt;

   // Ready depends only on the holding-register flag.
   assign o_din_ready = ~hold_full;
   assign accept      = i_din_valid & ~hold_full;
   assign load_pt     = (state == IDLE) | (cnt == LEN_C);
   assign o_busy      = hold_full | ((state == SHIFT) & (cnt < LEN_C));

   // Capture an incoming word into the holding register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hold <= '0;
      end else if (accept) begin
         hold <= iv_din;
      end
   end

   // Shift FSM: load from hold at word boundaries, else emit next bit.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         shreg        <= '0;
         hold_full    <= 1'b0;
         o_dout       <= 1'b0;
         o_dout_valid <= 1'b0;
      end else begin
         if (accept) begin
            hold_full <= 1'b1;
         end
         if (i_en) begin
            if (load_pt) begin
               if (hold_full) begin
                  o_dout       <= hold[0];
                  shreg        <= hold >> 1;
                  cnt          <= ONE_C;
                  hold_full    <= 1'b0;
                  state        <= SHIFT;
                  o_dout_valid <= 1'b0;
               end else begin
                  o_dout       <= 1'b0;
                  o_dout_valid <= 1'b0;
                  state        <= IDLE;
                  cnt          <= '0;
               end
            end else begin
               o_dout       <= shreg[0];
               shreg        <= shreg >> 1;
               cnt          <= cnt + ONE_C;
               o_dout_valid <= (cnt == LAST_C);
            end
         end
      end
   end

endmodule

// File: tb/tb_serializer.sv
// Directed bench for serializer: reset, single word, back-to-back,
// slow strobe, mid-word reset and input stall.
module tb_serializer;

   localparam int L = 24;

   logic         i_clk = 1'b0;
   logic         i_rst_n = 1'b0;
   logic         i_en = 1'b0;
   logic [L-1:0] iv_din = '0;
   logic         i_din_valid = 1'b0;
   logic         o_din_ready;
   logic         o_dout;
   logic         o_dout_valid;
   logic         o_busy;

   serializer #(.LENGTH(L)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_en         (i_en),
      .iv_din       (iv_din),
      .i_din_valid  (i_din_valid),
      .o_din_ready  (o_din_ready),
      .o_dout       (o_dout),
      .o_dout_valid (o_dout_valid),
      .o_busy       (o_busy)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;
   int en_div = 1;

   logic         q_bit[$];
   logic         q_val[$];
   logic         q_busy[$];
   logic [L-1:0] rxq[$];
   logic [L-1:0] sr;
   logic         busy_prev;

   // Loopback deserializer: one sample per strobe, word latched on marker.
   always @(negedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         busy_prev = 1'b0;
         sr        = '0;
      end else begin
         if (i_en) begin
            q_bit.push_back(o_dout);
            q_val.push_back(o_dout_valid);
            q_busy.push_back(busy_prev);
            sr = {o_dout, sr[L-1:1]};
            if (o_dout_valid) rxq.push_back(sr);
         end
         busy_prev = o_busy;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge i_clk);
      #1;
      cyc++;
      i_en = ((cyc % en_div) == 0);
   endtask

   task automatic clearq();
      q_bit.delete();
      q_val.delete();
      q_busy.delete();
      rxq.delete();
   endtask

   task automatic send(input logic [L-1:0] w, output int acc);
      int   g;
      logic ok;
      iv_din      = w;
      i_din_valid = 1'b1;
      g           = 0;
      do begin
         ok = o_din_ready;
         tick();
         g++;
      end while (!ok && g < 200);
      i_din_valid = 1'b0;
      acc         = cyc;
      chk($sformatf("accept_%h", w), ok, 1);
   endtask

   task automatic check_word(input logic [L-1:0] w, input string tag);
      for (int i = 0; i < L; i++) begin
         tick();
         chk($sformatf("%s_bit%0d", tag, i), o_dout, w[i]);
         chk($sformatf("%s_mark%0d", tag, i), o_dout_valid, (i == L - 1));
      end
   endtask

   function automatic logic [L-1:0] rx_at(input int k);
      return (rxq.size() > k) ? rxq[k] : 'x;
   endfunction

   initial begin
      int c1, c2, c3, a, b, first, run, errs, idx, nmark;
      logic en_b, ok;
      logic [L-1:0] t3w[3];
      t3w[0] = 24'h123456;
      t3w[1] = 24'hABCDEF;
      t3w[2] = 24'h000001;

      // reset state
      repeat (3) tick();
      i_rst_n = 1'b1;
      tick();
      chk("rst_ready", o_din_ready, 1);
      chk("rst_dout", o_dout, 0);
      chk("rst_valid", o_dout_valid, 0);
      chk("rst_busy", o_busy, 0);

      // single word
      clearq();
      send(24'hA5C3F1, c1);
      chk("t2_ready_low", o_din_ready, 0);
      chk("t2_busy", o_busy, 1);
      check_word(24'hA5C3F1, "t2");
      tick();
      chk("t2_end_valid", o_dout_valid, 0);
      chk("t2_end_busy", o_busy, 0);
      chk("t2_end_dout", o_dout, 0);
      chk("t2_rx_n", rxq.size(), 1);
      chk("t2_rx_word", rx_at(0), 24'hA5C3F1);

      // back-to-back
      clearq();
      send(t3w[0], c1);
      send(t3w[1], c2);
      send(t3w[2], c3);
      chk("t3_w2_acc_cyc", c2 - c1, 2);
      chk("t3_w3_acc_cyc", c3 - c1, 26);
      repeat (60) tick();
      first = -1;
      for (int k = 0; k < q_busy.size(); k++)
         if (first < 0 && q_busy[k]) first = k;
      run = 0;
      if (first >= 0)
         while (first + run < q_busy.size() && q_busy[first + run]) run++;
      chk("t3_contig", run, 72);
      errs = 0;
      if (first >= 0 && first + 72 <= q_bit.size()) begin
         for (int k = 0; k < 72; k++) begin
            if (q_bit[first + k] !== t3w[k / L][k % L]) errs++;
            if (q_val[first + k] !== ((k % L) == L - 1)) errs++;
         end
      end else begin
         errs = 999;
      end
      chk("t3_bits_marks", errs, 0);
      chk("t3_rx_n", rxq.size(), 3);
      chk("t3_rx0", rx_at(0), t3w[0]);
      chk("t3_rx1", rx_at(1), t3w[1]);
      chk("t3_rx2", rx_at(2), t3w[2]);

      // slow strobe, every 4th cycle
      clearq();
      en_div = 4;
      cyc    = 0;
      i_en   = 1'b0;
      send(24'hFFFFFE, c1);
      idx = -1;
      for (int n = 0; n < L * 4 + 8; n++) begin
         en_b = i_en;
         tick();
         if (en_b) idx++;
         if (idx >= 0 && idx < L) begin
            chk($sformatf("t4_bit%0d_n%0d", idx, n), o_dout,
                (idx == 0) ? 1'b0 : 1'b1);
            chk($sformatf("t4_mark%0d_n%0d", idx, n), o_dout_valid,
                (idx == L - 1));
         end
      end
      chk("t4_rx_n", rxq.size(), 1);
      chk("t4_rx_word", rx_at(0), 24'hFFFFFE);
      en_div = 1;
      i_en   = 1'b1;

      // reset mid-word
      clearq();
      send(24'h0F0F0F, c1);
      repeat (10) tick();
      chk("t5_busy_mid", o_busy, 1);
      i_rst_n = 1'b0;
      #1;
      chk("t5_rst_ready", o_din_ready, 1);
      chk("t5_rst_dout", o_dout, 0);
      chk("t5_rst_valid", o_dout_valid, 0);
      chk("t5_rst_busy", o_busy, 0);
      tick();
      i_rst_n = 1'b1;
      nmark = 0;
      foreach (q_val[k]) if (q_val[k]) nmark++;
      chk("t5_no_marker", nmark, 0);
      chk("t5_no_rx", rxq.size(), 0);
      clearq();
      send(24'h800000, c1);
      check_word(24'h800000, "t5");
      tick();
      chk("t5_rx_n", rxq.size(), 1);
      chk("t5_rx_word", rx_at(0), 24'h800000);

      // input stall while ready is low
      clearq();
      send(24'h111111, a);
      send(24'h222222, b);
      chk("t6_b_acc_cyc", b - a, 2);
      iv_din      = 24'hDEAD00;
      i_din_valid = 1'b1;
      repeat (5) tick();
      chk("t6_ready_low", o_din_ready, 0);
      ok = 1'b0;
      for (int g = 0; g < 60 && !ok; g++) begin
         ok = o_din_ready;
         tick();
      end
      i_din_valid = 1'b0;
      chk("t6_accepted", ok, 1);
      chk("t6_acc_cyc", cyc - a, 26);
      repeat (60) tick();
      chk("t6_rx_n", rxq.size(), 3);
      chk("t6_rx0", rx_at(0), 24'h111111);
      chk("t6_rx1", rx_at(1), 24'h222222);
      chk("t6_rx2", rx_at(2), 24'hDEAD00);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
